perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 The block SHALL have parameter NUM_CTR, default 4, meaning the number of programmable event counters (legal range 1..8).
REQ-002 The block SHALL have parameter CTR_W, default 32, meaning the width of every counter (legal range 8..64).
REQ-003 The block SHALL have parameter EVT_W, default 8, meaning the number of event inputs (legal range 1..16).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, reset; reset SHALL be asynchronous and active-low.
REQ-006 The block SHALL have port retire_i, input, 1 bit, a one-cycle pulse per retired instruction.
REQ-007 The block SHALL have port evt_i, input, EVT_W bits, per-cycle event pulses (stall, flush, branch taken, dmem write, ...).
REQ-008 The block SHALL have port cfg_wen, input, 1 bit, a register write strobe.
REQ-009 The block SHALL have port cfg_addr, input, 5 bits, the register address for both writes and reads.
REQ-010 The block SHALL have port cfg_wdata, input, CTR_W bits, the write data.
REQ-011 The block SHALL have port rd_en, input, 1 bit, a read request.
REQ-012 The block SHALL have port rd_data, output, CTR_W bits, the registered read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit, asserted high for one cycle when rd_data holds the result of a read.
REQ-014 The block SHALL have port irq_o, output, 1 bit, the overflow interrupt.

Function
REQ-015 The register map SHALL be: 0x00 cycle; 0x01 instret; 0x02+i counter i; 0x10+i evtsel i; 0x18 CTRL; 0x19 OVF; 0x1A OVF_MASK.
REQ-016 CTRL SHALL contain bit0 EN, bit1 CLR and bit2 OVF_HALT; CLR SHALL be self-clearing and SHALL always read 0.
REQ-017 The block SHALL count only when EN=1, and not when OVF_HALT=1 with OVF nonzero (the halted state).
REQ-018 The cycle counter SHALL increment every counting cycle.
REQ-019 The instret counter SHALL increment on each counting cycle with retire_i=1.
REQ-020 Counter i SHALL increment on each counting cycle with evt_i[evtsel_i]=1; an evtsel_i >= EVT_W SHALL never count.
REQ-021 A counter SHALL wrap from all-ones to 0, and the wrap SHALL set its sticky OVF bit in the same cycle (bit0 cycle, bit1 instret, bit2+i counter i).
REQ-022 Each counter SHALL increment by at most 1 per cycle, and the increment SHALL be visible on the next read issued after that edge.
REQ-023 A write to a counter address SHALL load cfg_wdata; a write SHALL win over a same-cycle increment and SHALL NOT set OVF.
REQ-024 CLR=1 SHALL zero all counters and OVF on the same edge, taking priority over increments and counter writes in that cycle; EN and OVF_HALT SHALL take the written value.
REQ-025 OVF SHALL be write-1-to-clear, and a same-cycle overflow SHALL win over its clear.
REQ-026 Writes to unmapped addresses and to evtsel i >= NUM_CTR SHALL be ignored.
REQ-027 Reads SHALL have a latency of 1: rd_en at edge N SHALL give rd_data/rd_valid after edge N, holding the pre-edge-N register values.
REQ-028 A read and a write issued in the same cycle SHALL return the old value of the register.
REQ-029 Unmapped read addresses SHALL return 0.
REQ-030 rd_data SHALL hold its last value while rd_en=0, and rd_valid SHALL be 0 in that case.
REQ-031 Counter widths narrower than CTR_W SHALL NOT exist; writes of evtsel, CTRL and OVF_MASK SHALL use only their low-order bits, and their reads SHALL zero-extend.

Reset
REQ-032 While rst=0, the block SHALL immediately clear all counters, all evtsel, CTRL, OVF and OVF_MASK, and SHALL drive rd_data=0, rd_valid=0 and irq_o=0.
REQ-033 A reset mid-read SHALL drop that read with no rd_valid.
REQ-034 Counting SHALL remain stopped after reset until EN is written.

Configuration
REQ-035 The feature macro SHALL be PERF_OVF_IRQ_EN.
REQ-036 With PERF_OVF_IRQ_EN defined, irq_o SHALL be registered |(OVF & OVF_MASK), so it asserts on the cycle after the OVF bit sets and stays high until the bit is cleared or masked.
REQ-037 Without PERF_OVF_IRQ_EN, irq_o SHALL be tied to 0, OVF_MASK SHALL read 0 and writes to it SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-038 Write CTRL=1, run 100 cycles, read 0x00 -> rd_data=100 one cycle after rd_en, with rd_valid=1 for one cycle.
REQ-039 Set evtsel0=3, pulse evt_i[3] 7 times and evt_i[2] 5 times -> counter0=7, counter1=0; set evtsel1=20 -> counter1 never increments.
REQ-040 With CTR_W=8, write counter0=0xFE, apply two events -> counter0=0x00, OVF=0x04; with OVF_HALT=1, cycle stops advancing; write OVF=0x04 -> counting resumes.
REQ-041 Write counter0=0x55 in the same cycle as an event -> reads 0x55; write CLR alongside events -> all counters read 0 and OVF=0.
REQ-042 With PERF_OVF_IRQ_EN defined and OVF_MASK=0x02, an instret wrap -> irq_o=1 on the next cycle, and writing OVF=0x02 -> irq_o=0; without the macro -> irq_o stays 0.
REQ-043 Assert rst low mid-count and mid-read -> all outputs are 0 asynchronously, no rd_valid, and all registers read 0 after release.

Source files
------------

// File: rtl/perf_monitor.sv
// Performance monitor: cycle, instret and NUM_CTR event counters behind a small register file.
// Define PERF_OVF_IRQ_EN to enable OVF_MASK and the registered overflow interrupt on irq_o.
`timescale 1ns/1ps
module perf_monitor #(
  parameter int unsigned NUM_CTR = 4,
  parameter int unsigned CTR_W   = 32,
  parameter int unsigned EVT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_i,
  input  logic [EVT_W-1:0] evt_i,
  input  logic             cfg_wen,
  input  logic [4:0]       cfg_addr,
  input  logic [CTR_W-1:0] cfg_wdata,
  input  logic             rd_en,
  output logic [CTR_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             irq_o
);

  // Counter k (0 cycle, 1 instret, 2+i event counter i) lives at address k and OVF bit k.
  localparam int unsigned OVF_W = NUM_CTR + 2;
  localparam int unsigned WD_W  = (OVF_W > CTR_W) ? OVF_W : CTR_W;

  logic [CTR_W-1:0] cnt_q    [OVF_W];
  logic [CTR_W-1:0] cnt_d    [OVF_W];
  logic [4:0]       evtsel_q [NUM_CTR];
  logic [4:0]       evtsel_d [NUM_CTR];
  logic             en_q, en_d, halt_q, halt_d;
  logic [OVF_W-1:0] ovf_q, ovf_d, inc, wrap;
  logic [WD_W-1:0]  wdata_ext;
  logic [31:0]      evt_pad;
  logic [CTR_W-1:0] rd_mux;
  logic             wr_ctrl, clr, wr_ovf, count_en;
`ifdef PERF_OVF_IRQ_EN
  logic [OVF_W-1:0] mask_q, mask_d;
  logic             wr_mask;
`endif

  assign wdata_ext = WD_W'(cfg_wdata);
  // Zero padding makes any evtsel >= EVT_W select a constant-0 event.
  assign evt_pad   = 32'(evt_i);
  assign wr_ctrl   = cfg_wen && (cfg_addr == 5'h18);
  assign clr       = wr_ctrl && wdata_ext[1];
  assign wr_ovf    = cfg_wen && (cfg_addr == 5'h19);
  assign count_en  = en_q && !(halt_q && (|ovf_q));
`ifdef PERF_OVF_IRQ_EN
  assign wr_mask   = cfg_wen && (cfg_addr == 5'h1A);
`endif

  always_comb begin
    inc    = '0;
    inc[0] = count_en;
    inc[1] = count_en && retire_i;
    for (int i = 0; i < NUM_CTR; i++) begin
      inc[2+i] = count_en && evt_pad[evtsel_q[i]];
    end
  end

  always_comb begin
    wrap = '0;
    for (int k = 0; k < OVF_W; k++) begin
      cnt_d[k] = cnt_q[k];
      if (clr) begin
        cnt_d[k] = '0;
      end else if (cfg_wen && (cfg_addr == 5'(k))) begin
        cnt_d[k] = wdata_ext[CTR_W-1:0];
      end else if (inc[k]) begin
        cnt_d[k] = cnt_q[k] + CTR_W'(1);
        wrap[k]  = &cnt_q[k];
      end
    end
    for (int i = 0; i < NUM_CTR; i++) begin
      evtsel_d[i] = evtsel_q[i];
      if (cfg_wen && (cfg_addr == 5'(16 + i))) evtsel_d[i] = wdata_ext[4:0];
    end
    en_d   = wr_ctrl ? wdata_ext[0] : en_q;
    halt_d = wr_ctrl ? wdata_ext[2] : halt_q;
    // Set beats write-1-to-clear for a same-cycle wrap.
    if (clr) ovf_d = '0;
    else     ovf_d = (ovf_q & ~(wr_ovf ? wdata_ext[OVF_W-1:0] : '0)) | wrap;
`ifdef PERF_OVF_IRQ_EN
    mask_d = wr_mask ? wdata_ext[OVF_W-1:0] : mask_q;
`endif
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < OVF_W; k++) begin
      if (cfg_addr == 5'(k)) rd_mux = cnt_q[k];
    end
    for (int i = 0; i < NUM_CTR; i++) begin
      if (cfg_addr == 5'(16 + i)) rd_mux = CTR_W'(evtsel_q[i]);
    end
    if (cfg_addr == 5'h18) rd_mux = CTR_W'({halt_q, 1'b0, en_q});
    if (cfg_addr == 5'h19) rd_mux = CTR_W'(ovf_q);
`ifdef PERF_OVF_IRQ_EN
    if (cfg_addr == 5'h1A) rd_mux = CTR_W'(mask_q);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < OVF_W; k++) cnt_q[k] <= '0;
      for (int i = 0; i < NUM_CTR; i++) evtsel_q[i] <= '0;
      en_q     <= 1'b0;
      halt_q   <= 1'b0;
      ovf_q    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef PERF_OVF_IRQ_EN
      mask_q   <= '0;
      irq_o    <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < OVF_W; k++) cnt_q[k] <= cnt_d[k];
      for (int i = 0; i < NUM_CTR; i++) evtsel_q[i] <= evtsel_d[i];
      en_q     <= en_d;
      halt_q   <= halt_d;
      ovf_q    <= ovf_d;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
`ifdef PERF_OVF_IRQ_EN
      mask_q   <= mask_d;
      irq_o    <= |(ovf_q & mask_q);
`endif
    end
  end

`ifndef PERF_OVF_IRQ_EN
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// Directed bench for perf_monitor (CTR_W=8 so wrap cases are short); inputs change on negedge.
`timescale 1ns/1ps
module tb_perf_monitor;
  localparam int unsigned NUM_CTR = 4;
  localparam int unsigned CTR_W   = 8;
  localparam int unsigned EVT_W   = 8;
`ifdef PERF_OVF_IRQ_EN
  localparam logic IrqEn = 1'b1;
`else
  localparam logic IrqEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             retire_i;
  logic [EVT_W-1:0] evt_i;
  logic             cfg_wen;
  logic [4:0]       cfg_addr;
  logic [CTR_W-1:0] cfg_wdata;
  logic             rd_en;
  logic [CTR_W-1:0] rd_data;
  logic             rd_valid;
  logic             irq_o;
  int               errors = 0;
  int               checks = 0;

  perf_monitor #(.NUM_CTR(NUM_CTR), .CTR_W(CTR_W), .EVT_W(EVT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .retire_i  (retire_i),
    .evt_i     (evt_i),
    .cfg_wen   (cfg_wen),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cfg_wen = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_wen = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string tag);
    cfg_addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check(tag, 64'(rd_data), 64'(exp));
    check({tag, "_valid"}, 64'(rd_valid), 64'd1);
  endtask

  task automatic pulse(input int b, input int n);
    for (int j = 0; j < n; j++) begin
      evt_i = EVT_W'(1 << b);
      @(negedge clk);
      evt_i = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; retire_i = 1'b0; evt_i = '0; cfg_wen = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; rd_en = 1'b0;
    #12;
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    rd(5'h18, 8'h00, "ctrl_after_rst");
    rd(5'h00, 8'h00, "cycle_stopped");

    // 100 counting cycles
    wr(5'h18, 8'h01);
    repeat (100) @(negedge clk);
    rd(5'h00, 8'd100, "cycle_100");
    @(negedge clk);
    check("rd_valid_drop", 64'(rd_valid), 64'd0);
    check("rd_data_hold", 64'(rd_data), 64'd100);
    rd(5'h1F, 8'h00, "unmapped_rd");
    wr(5'h18, 8'h02);

    // Event selection
    wr(5'h10, 8'd3);
    wr(5'h18, 8'h01);
    pulse(3, 7);
    pulse(2, 5);
    wr(5'h18, 8'h00);
    rd(5'h02, 8'd7, "ctr0_evt3");
    rd(5'h03, 8'd0, "ctr1_evt0");
    wr(5'h11, 8'd20);
    wr(5'h14, 8'd5);
    rd(5'h11, 8'd20, "evtsel1_rd");
    rd(5'h14, 8'd0, "evtsel4_ignored");
    wr(5'h18, 8'h01);
    evt_i = 8'hFF;
    repeat (3) @(negedge clk);
    evt_i = '0;
    wr(5'h18, 8'h00);
    rd(5'h02, 8'd10, "ctr0_all_evt");
    rd(5'h03, 8'd0, "ctr1_sel20");
    rd(5'h04, 8'd3, "ctr2_sel0");
    wr(5'h18, 8'h02);

    // Wrap, sticky OVF and halt
    wr(5'h02, 8'hFE);
    wr(5'h18, 8'h05);
    pulse(3, 2);
    rd(5'h02, 8'h00, "ctr0_wrap");
    rd(5'h19, 8'h04, "ovf_ctr0");
    rd(5'h00, 8'd3, "cycle_halted");
    pulse(3, 2);
    rd(5'h02, 8'h00, "ctr0_halted");
    rd(5'h00, 8'd3, "cycle_still_halted");
    wr(5'h19, 8'h04);
    repeat (5) @(negedge clk);
    rd(5'h00, 8'd8, "cycle_resumed");
    rd(5'h19, 8'h00, "ovf_cleared");
    wr(5'h18, 8'h02);

    // Write beats increment, read-during-write, CLR beats everything
    wr(5'h18, 8'h01);
    evt_i = 8'h08;
    wr(5'h02, 8'h55);
    evt_i = '0;
    wr(5'h18, 8'h00);
    rd(5'h02, 8'h55, "ctr0_write_wins");
    cfg_wen = 1'b1; cfg_addr = 5'h02; cfg_wdata = 8'h11; rd_en = 1'b1;
    @(negedge clk);
    cfg_wen = 1'b0; rd_en = 1'b0;
    check("rd_during_wr_old", 64'(rd_data), 64'h55);
    rd(5'h02, 8'h11, "ctr0_new");
    wr(5'h18, 8'h01);
    evt_i = 8'hFF; retire_i = 1'b1;
    repeat (4) @(negedge clk);
    wr(5'h18, 8'h02);
    evt_i = '0; retire_i = 1'b0;
    rd(5'h00, 8'h00, "clr_cycle");
    rd(5'h01, 8'h00, "clr_instret");
    rd(5'h02, 8'h00, "clr_ctr0");
    rd(5'h03, 8'h00, "clr_ctr1");
    rd(5'h19, 8'h00, "clr_ovf");
    rd(5'h18, 8'h00, "clr_reads_0");
    wr(5'h18, 8'hFD);
    rd(5'h18, 8'h05, "ctrl_low_bits");
    wr(5'h18, 8'h02);

    // Masked instret overflow interrupt
    wr(5'h1A, 8'h02);
    rd(5'h1A, IrqEn ? 8'h02 : 8'h00, "mask_rd");
    wr(5'h01, 8'hFF);
    wr(5'h18, 8'h01);
    retire_i = 1'b1;
    @(negedge clk);
    retire_i = 1'b0;
    check("irq_not_yet", 64'(irq_o), 64'd0);
    rd(5'h19, 8'h02, "ovf_instret");
    check("irq_set", 64'(irq_o), 64'(IrqEn));
    rd(5'h01, 8'h00, "instret_wrapped");
    wr(5'h18, 8'h00);
    wr(5'h19, 8'h02);
    check("irq_hold_clear_edge", 64'(irq_o), 64'(IrqEn));
    @(negedge clk);
    check("irq_cleared", 64'(irq_o), 64'd0);

    // Asynchronous reset mid-count and mid-read
    wr(5'h18, 8'h01);
    rd(5'h10, 8'd3, "evtsel0_pre_rst");
    cfg_addr = 5'h00; rd_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("async_rd_data", 64'(rd_data), 64'd0);
    check("async_rd_valid", 64'(rd_valid), 64'd0);
    check("async_irq", 64'(irq_o), 64'd0);
    @(negedge clk);
    check("rst_no_valid", 64'(rd_valid), 64'd0);
    rd_en = 1'b0;
    rst = 1'b1;
    rd(5'h18, 8'h00, "post_rst_ctrl");
    rd(5'h00, 8'h00, "post_rst_cycle");
    rd(5'h01, 8'h00, "post_rst_instret");
    rd(5'h02, 8'h00, "post_rst_ctr0");
    rd(5'h10, 8'h00, "post_rst_evtsel0");
    rd(5'h19, 8'h00, "post_rst_ovf");
    rd(5'h1A, 8'h00, "post_rst_mask");
    repeat (3) @(negedge clk);
    rd(5'h00, 8'h00, "post_rst_no_count");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
